moore_stream_ctrl: RTL and testbench

- Controller that sequences a serial Moore sequence detector for "1011" with overlap, from a parallel word interface.
- Accepts one WORD_W-bit word over a valid/ready handshake and clears the detector history.
- Shifts the word MSB-first into the detector, one bit per clock, and counts cycles where the Moore output z is high.
- Reports the match count with a one-cycle done pulse. Sits between a word-oriented producer and the bit-serial detector.

---
 rtl/moore_stream_ctrl_pkg.sv | 22 ++
 rtl/moore_stream_ctrl_if.sv | 12 +
 rtl/moore_seq_det.sv | 38 +++
 rtl/moore_stream_ctrl.sv | 93 +++++++++
 tb/tb_moore_stream_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/moore_stream_ctrl_pkg.sv
// Shared encodings for the word-to-serial "1011" detection controller and
// its bit-serial Moore detector.
package moore_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_e;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/moore_stream_ctrl_if.sv
// Valid/ready word handshake between a producer (master) and the
// controller (slave).
interface moore_stream_ctrl_if #(
  parameter int WORD_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/moore_seq_det.sv
// Overlapping "1011" Moore detector: z is a function of the registered
// state only, so it rises the cycle after the fourth matching bit.
module moore_seq_det
  import moore_stream_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic x,
  output logic z
);

  det_state_e state, state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S0;
    else      state <= state_nxt;
  end

  // NOTE: every variable written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S0:      state_nxt = x ? S1 : S0;
      S1:      state_nxt = x ? S1 : S2;
      S2:      state_nxt = x ? S3 : S0;
      S3:      state_nxt = x ? S4 : S2;
      S4:      state_nxt = x ? S1 : S2;
      default: state_nxt = S0;
    endcase
    // Clear wins over the data bit so history never spans words.
    if (clr) state_nxt = S0;
  end

  assign z = (state == S4);

endmodule

// File: rtl/moore_stream_ctrl.sv
// Accepts a word, serialises it MSB-first into the Moore detector and
// counts cycles with z high; done pulses once when match_cnt is final.
module moore_stream_ctrl
  import moore_stream_ctrl_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  moore_stream_ctrl_if.slave in_if,
  output logic             busy,
  output logic             z,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  if ((2 ** CNT_W) <= WORD_W) begin : g_cnt_w_check
    $error("CNT_W too narrow to hold WORD_W matches");
  end

  ctrl_state_e      state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              det_x;
  logic              det_z;
  logic              counting;

  assign accept   = (state == IDLE) && in_if.in_valid;
  assign counting = (state == SHIFT) || (state == DRAIN);
  // Outside SHIFT the detector sees zeros; only its S4 visibility in DRAIN matters.
  assign det_x    = (state == SHIFT) && shreg[WORD_W-1];

  moore_seq_det u_det (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .x   (det_x),
    .z   (det_z)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_if.in_valid) state_nxt = SHIFT;
      SHIFT:   if (idx == '0)      state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift register is a handful of flops, not a memory array, so
  // it is reset like any other state to keep post-reset behaviour defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (accept) begin
      shreg <= in_if.in_data;
      idx   <= IDX_W'(WORD_W - 1);
    end else if (state == SHIFT) begin
      shreg <= {shreg[WORD_W-2:0], 1'b0};
      if (idx != '0) idx <= idx - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (accept) begin
      match_cnt <= '0;
    end else if (counting && det_z && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  assign in_if.in_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign z              = det_z;

endmodule

// File: tb/tb_moore_stream_ctrl.sv
// Self-checking bench for moore_stream_ctrl: a table of words with their
// expected "1011" counts feeds a scoreboard popped on every done pulse.
module tb_moore_stream_ctrl;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  exp_cnt;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             busy;
  logic             z;
  logic             done;
  logic [CNT_W-1:0] match_cnt;

  moore_stream_ctrl_if #(.WORD_W(WORD_W)) sif ();

  moore_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (sif),
    .busy      (busy),
    .z         (z),
    .done      (done),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [CNT_W-1:0] sb[$];
  logic done_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Independent reference: count 4-bit windows equal to 1011 inside the word.
  function automatic logic [CNT_W-1:0] ref_count(input logic [WORD_W-1:0] w);
    logic [3:0] pat;
    logic [CNT_W-1:0] c;
    pat = 4'b1011;
    c = '0;
    for (int i = WORD_W - 1; i >= 3; i--)
      if (w[i -: 4] == pat) c++;
    return c;
  endfunction

  // Scoreboard monitor: every done pulse pops one expected count.
  always @(negedge clk) begin
    if (!rst) begin
      done_prev <= 1'b0;
    end else begin
      if (done) begin
        check("done_width", {31'd0, done_prev}, 32'd0);
        if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("match_cnt", {28'd0, match_cnt}, {28'd0, sb.pop_front()});
      end
      done_prev <= done;
    end
  end

  task automatic send(input logic [WORD_W-1:0] d, input bit push);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!sif.in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) check("send_timeout", 32'd1, 32'd0);
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    if (push) sb.push_back(ref_count(d));
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    sif.in_data  = WORD_W'($urandom);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && sif.in_ready) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int lat;
    vecs[0] = '{8'b0000_0000, 4'd0};
    vecs[1] = '{8'b1011_1011, 4'd2};
    vecs[2] = '{8'b1010_1011, 4'd1};
    vecs[3] = '{8'b0000_0101, 4'd0};
    vecs[4] = '{8'b1000_0000, 4'd0};
    vecs[5] = '{8'b1011_0000, 4'd1};
    vecs[6] = '{8'b1101_1011, 4'd2};

    rst          = 1'b1;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;

    // Asynchronous reset asserted mid-cycle takes effect immediately.
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_in_ready",  {31'd0, sif.in_ready}, 32'd1);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_done",      {31'd0, done}, 32'd0);
    check("rst_z",         {31'd0, z}, 32'd0);
    check("rst_match_cnt", {28'd0, match_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Cycle-exact timing of one transaction, z mirrored after bits 4 and 7.
    send(8'b1011_0110, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("t2_busy_c%0d", k),  {31'd0, busy}, {31'd0, (k <= 10)});
      check($sformatf("t2_done_c%0d", k),  {31'd0, done}, {31'd0, (k == 10)});
      check($sformatf("t2_ready_c%0d", k), {31'd0, sif.in_ready}, {31'd0, (k == 11)});
      check($sformatf("t2_z_c%0d", k),     {31'd0, z}, {31'd0, (k == 5 || k == 8)});
    end
    check("t2_cnt_held", {28'd0, match_cnt}, 32'd2);
    check("t2_table_ref", {28'd0, ref_count(8'b1011_0110)}, 32'd2);

    // Table-driven words, back to back; the monitor compares each done.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("vec%0d_ref", i), {28'd0, ref_count(vecs[i].data)}, {28'd0, vecs[i].exp_cnt});
      send(vecs[i].data, 1'b1);
    end
    wait_idle();

    for (int i = 0; i < 6; i++) send(WORD_W'($urandom), 1'b1);
    wait_idle();

    // in_valid held high: second word taken only on the first IDLE cycle.
    @(negedge clk);
    sif.in_valid = 1'b1;
    sif.in_data  = 8'b1011_1011;
    sb.push_back(ref_count(8'b1011_1011));
    @(posedge clk);
    #1;
    sif.in_data = 8'b1010_1011;
    sb.push_back(ref_count(8'b1010_1011));
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("t5_ready_c%0d", k), {31'd0, sif.in_ready}, {31'd0, (k == 11)});
    end
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    @(negedge clk);
    check("t5_second_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset during SHIFT cycle 3 aborts the word with no done pulse.
    send(8'b1011_0110, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_busy",  {31'd0, busy}, 32'd0);
    check("t6_ready", {31'd0, sif.in_ready}, 32'd1);
    check("t6_cnt",   {28'd0, match_cnt}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("t6_no_done", {31'd0, done}, 32'd0);
    end
    rst = 1'b1;
    send(8'b1011_0000, 1'b1);
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("t6_latency", 32'(lat), 32'd10);
    wait_idle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
